// File: rtl/array_feeder.sv
// array_feeder
//   Transmit side of the output-stationary systolic array interface. Accepts one
//   ifm vector and one wght vector per reduction step through a valid/ready
//   handshake. It holds each pair for one bit-serial MAC slot of 2**IDEPTH cycles
//   and skews rows and columns to match PE forwarding. After the last step it
//   lets the skew pipes empty, then runs the en_o/clr_o drain sequence and
//   pulses done.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start, k_len          begin a tile of k_len reduction steps (sampled in IDLE)
//   in_valid, in_ready    handshake for in_ifm / in_wght
//   in_ifm, in_wght       signed operand vectors (element h -> row h, w -> column w)
//   en_i, clr_i, mac_done per-row controls, row h delayed h+1 cycles
//   ifm                   per-row operand, aligned with en_i
//   en_w, clr_w, wght     per-column weight controls/operand, column w delayed w+1
//   en_o, clr_o           per-column ofm shift enable / register clear
//   busy                  high in any state but IDLE
//   done                  one-cycle pulse in the last TAIL cycle
//
// state | meaning
// IDLE  | waiting for start with non-zero k_len
// LOAD  | accepting vectors, one per MAC slot, until k_len steps are issued
// FLUSH | HEIGHT+WIDTH cycles with no controls so the skew pipes empty
// DRAIN | en_o for HEIGHT cycles, then clr_o for one cycle
// TAIL  | WIDTH cycles for the drain skew to finish; done on the last one

module array_feeder #(
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 8,
  parameter int IDEPTH = 3,
  parameter int KWIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KWIDTH-1:0]              k_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [HEIGHT-1:0][IWIDTH-1:0]  in_ifm,
  input  logic [WIDTH-1:0][IWIDTH-1:0]   in_wght,
  output logic [HEIGHT-1:0]              en_i,
  output logic [HEIGHT-1:0]              clr_i,
  output logic [HEIGHT-1:0]              mac_done,
  output logic [HEIGHT-1:0][IWIDTH-1:0]  ifm,
  output logic [WIDTH-1:0]               en_w,
  output logic [WIDTH-1:0]               clr_w,
  output logic [WIDTH-1:0][IWIDTH-1:0]   wght,
  output logic [WIDTH-1:0]               en_o,
  output logic [WIDTH-1:0]               clr_o,
  output logic                           busy,
  output logic                           done
);

  localparam int SLOT = 2 ** IDEPTH;
  localparam int PW   = $clog2(HEIGHT + WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    TAIL  = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [KWIDTH-1:0]               k_q, k_d;
  logic [KWIDTH-1:0]               step_q, step_d;
  logic [IDEPTH-1:0]               slot_q, slot_d;
  logic [PW-1:0]                   phase_q, phase_d;
  logic                            done_q, done_d;
  logic [HEIGHT-1:0][IWIDTH-1:0]   ifm_q, ifm_d;
  logic [WIDTH-1:0][IWIDTH-1:0]    wght_q, wght_d;

  // Unskewed controls, one value per cycle, fanned out through the skew pipes
  logic ready_c, accept, en_u, clr_u, mac_u, en_o_u, clr_o_u;

  logic [HEIGHT-1:0] en_row_q, clr_row_q, mac_row_q;
  logic [WIDTH-1:0]  en_col_q, clr_col_q, en_o_col_q, clr_o_col_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    slot_d  = slot_q;
    phase_d = phase_q;
    ifm_d   = ifm_q;
    wght_d  = wght_q;
    ready_c = 1'b0;
    accept  = 1'b0;
    en_u    = 1'b0;
    clr_u   = 1'b0;
    mac_u   = 1'b0;
    en_o_u  = 1'b0;
    clr_o_u = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = LOAD;
          k_d     = k_len;
          step_d  = '0;
          slot_d  = '0;
        end
      end

      LOAD: begin
        ready_c = (slot_q == '0) && (step_q < k_q);
        accept  = ready_c && in_valid;
        // Slot position 0 is the accept cycle itself; a non-zero slot counter
        // means a slot is in flight and runs to completion regardless of valid.
        en_u    = accept || (slot_q != '0);
        clr_u   = accept && (step_q == '0);
        mac_u   = en_u && (slot_q == IDEPTH'(SLOT - 1));
        if (accept) begin
          ifm_d  = in_ifm;
          wght_d = in_wght;
        end
        if (en_u) slot_d = slot_q + IDEPTH'(1);
        if (mac_u) begin
          step_d = step_q + KWIDTH'(1);
          if (step_q == k_q - KWIDTH'(1)) begin
            state_d = FLUSH;
            phase_d = PW'(HEIGHT + WIDTH - 1);
          end
        end
      end

      FLUSH: begin
        if (phase_q == '0) begin
          state_d = DRAIN;
          phase_d = PW'(HEIGHT);
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      DRAIN: begin
        // phase HEIGHT..1 shifts the ofm out, phase 0 clears it
        en_o_u  = (phase_q != '0);
        clr_o_u = (phase_q == '0);
        if (phase_q == '0) begin
          state_d = TAIL;
          phase_d = PW'(WIDTH - 1);
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      TAIL: begin
        if (phase_q == '0) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered done lands exactly on the last TAIL cycle
    done_d = (state_d == TAIL) && (phase_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      step_q      <= '0;
      slot_q      <= '0;
      phase_q     <= '0;
      done_q      <= 1'b0;
      ifm_q       <= '0;
      wght_q      <= '0;
      en_row_q    <= '0;
      clr_row_q   <= '0;
      mac_row_q   <= '0;
      en_col_q    <= '0;
      clr_col_q   <= '0;
      en_o_col_q  <= '0;
      clr_o_col_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      step_q  <= step_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      ifm_q   <= ifm_d;
      wght_q  <= wght_d;
      en_row_q[0]    <= en_u;
      clr_row_q[0]   <= clr_u;
      mac_row_q[0]   <= mac_u;
      en_col_q[0]    <= en_u;
      clr_col_q[0]   <= clr_u;
      en_o_col_q[0]  <= en_o_u;
      clr_o_col_q[0] <= clr_o_u;
      for (int h = 1; h < HEIGHT; h++) begin
        en_row_q[h]  <= en_row_q[h-1];
        clr_row_q[h] <= clr_row_q[h-1];
        mac_row_q[h] <= mac_row_q[h-1];
      end
      for (int w = 1; w < WIDTH; w++) begin
        en_col_q[w]    <= en_col_q[w-1];
        clr_col_q[w]   <= clr_col_q[w-1];
        en_o_col_q[w]  <= en_o_col_q[w-1];
        clr_o_col_q[w] <= clr_o_col_q[w-1];
      end
    end
  end

  // Triangular data pipes: lane h carries only its own element, h+1 deep,
  // so the operand arrives in lockstep with that lane's enable.
  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    logic [IWIDTH-1:0] pipe_q [h+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= h; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= ifm_d[h];
        for (int i = 1; i <= h; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign ifm[h] = pipe_q[h];
  end

  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    logic [IWIDTH-1:0] pipe_q [w+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= w; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= wght_d[w];
        for (int i = 1; i <= w; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign wght[w] = pipe_q[w];
  end

  assign in_ready = ready_c;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign en_i     = en_row_q;
  assign clr_i    = clr_row_q;
  assign mac_done = mac_row_q;
  assign en_w     = en_col_q;
  assign clr_w    = clr_col_q;
  assign en_o     = en_o_col_q;
  assign clr_o    = clr_o_col_q;

endmodule
